// File: rtl/sha_job_sequencer.sv
// Nonce-search sequencer for a chained pair of sha_unit instances (double SHA-256).
// Optional saturating hash counter output enabled by defining SHA_SEQ_HASHCOUNT_EN.
module sha_job_sequencer #(
    parameter int ZERO_BITS   = 8,
    parameter int NONCE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NONCE_WIDTH-1:0] nonce_start,
    input  logic [NONCE_WIDTH-1:0] nonce_end,
    input  logic [255:0]           h_final,
    output logic [5:0]             round,
    output logic [31:0]            Kt,
    output logic [NONCE_WIDTH-1:0] nonce,
    output logic                   capture,
    output logic                   busy,
    output logic                   found,
    output logic                   exhausted,
    output logic [NONCE_WIDTH-1:0] found_nonce
`ifdef SHA_SEQ_HASHCOUNT_EN
    ,
    output logic [31:0]            hash_count
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_HASH1, S_HASH2, S_CHECK, S_DONE} state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [NONCE_WIDTH-1:0] NONCE_ONE = 1;

    state_t                 state_q, state_d;
    logic [5:0]             round_q, round_d;
    logic [NONCE_WIDTH-1:0] nonce_q, nonce_d;
    logic [NONCE_WIDTH-1:0] nonce_end_q, nonce_end_d;
    logic                   found_q, found_d;
    logic                   exhausted_q, exhausted_d;
    logic [NONCE_WIDTH-1:0] found_nonce_q, found_nonce_d;
    logic                   accept;
    logic [31:0]            last_word;
    logic                   hit;
    logic                   unused_hi;

    // Only the last digest word is judged, byte-reversed to match the block-header order.
    assign last_word = {h_final[7:0], h_final[15:8], h_final[23:16], h_final[31:24]};
    assign hit       = (last_word >> (32 - ZERO_BITS)) == 32'd0;
    assign unused_hi = ^h_final[255:32];
    assign accept    = start && !stop && (state_q == S_IDLE || state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            round_q       <= '0;
            nonce_q       <= '0;
            nonce_end_q   <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            found_nonce_q <= '0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            nonce_q       <= nonce_d;
            nonce_end_q   <= nonce_end_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            found_nonce_q <= found_nonce_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        nonce_d       = nonce_q;
        nonce_end_d   = nonce_end_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        found_nonce_d = found_nonce_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                round_d = '0;
                if (accept) begin
                    state_d     = S_HASH1;
                    nonce_d     = nonce_start;
                    nonce_end_d = nonce_end;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                end
            end
            S_HASH1: begin
                round_d = round_q + 6'd1;
                if (round_q == 6'd63) state_d = S_HASH2;
            end
            S_HASH2: begin
                round_d = round_q + 6'd1;
                if (round_q == 6'd63) state_d = S_CHECK;
            end
            S_CHECK: begin
                round_d = '0;
                if (hit) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                    state_d       = S_DONE;
                // >= also ends reversed ranges after one nonce and prevents wrap past all-ones.
                end else if (nonce_q >= nonce_end_q) begin
                    exhausted_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    nonce_d = nonce_q + NONCE_ONE;
                    state_d = S_HASH1;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
            end
        endcase
        if (stop) begin
            state_d       = S_IDLE;
            round_d       = '0;
            nonce_d       = nonce_q;
            nonce_end_d   = nonce_end_q;
            found_d       = found_q;
            exhausted_d   = exhausted_q;
            found_nonce_d = found_nonce_q;
        end
    end

    always_comb begin
        busy    = (state_q == S_HASH1) || (state_q == S_HASH2) || (state_q == S_CHECK);
        capture = (state_q == S_HASH2) && (round_q == 6'd0);
        Kt      = K_ROM[round_q];
    end

    assign round       = round_q;
    assign nonce       = nonce_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign found_nonce = found_nonce_q;

`ifdef SHA_SEQ_HASHCOUNT_EN
    logic [31:0] hcnt_q, hcnt_d;

    always_comb begin
        hcnt_d = hcnt_q;
        if (accept) hcnt_d = '0;
        else if (state_q == S_CHECK && hcnt_q != 32'hFFFFFFFF) hcnt_d = hcnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) hcnt_q <= '0;
        else       hcnt_q <= hcnt_d;
    end

    assign hash_count = hcnt_q;
`endif

endmodule
